snes_button_events: RTL

- Sits directly downstream of snes_gamepad and drives its rd/busy handshake.
- Polls the pad periodically and captures the 16-bit button word.
- Debounces the word across consecutive polls and turns accepted changes into press/release events.
- Events are buffered in a small FIFO with a valid/ready output, so CPU or UI logic consumes button events instead of raw levels.

---
 rtl/snes_pkg.sv | 30 +++
 rtl/snes_evt_fifo.sv | 48 ++++
 rtl/snes_button_events.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snes_pkg.sv
// Shared constants and FSM encoding for the SNES button event unit.
package snes_pkg;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int EVT_W      = 5;
  localparam int IDX_W      = 4;
  localparam int WAIT_LIMIT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_READ,
    S_FILT,
    S_SCAN
  } fsm_t;

endpackage

// File: rtl/snes_evt_fifo.sv
// Synchronous event FIFO; push accepted when full if a pop lands in the same cycle.
module snes_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/snes_button_events.sv
// Polls snes_gamepad, debounces the button word and queues press/release events.
module snes_button_events
  import snes_pkg::*;
#(
  parameter int POLL_CYCLES  = 1666667,
  parameter int STABLE_POLLS = 2,
  parameter int EVT_DEPTH    = 8,
  parameter int BUSY_TIMEOUT = 262144
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             pad_rd,
  input  logic             pad_busy,
  input  logic [15:0]      pad_buttons,
  output logic [15:0]      state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             timeout_err
);

  localparam int TW = $clog2(POLL_CYCLES);

  logic [TW-1:0]    timer;
  logic             tick;
  fsm_t             st;
  logic [31:0]      cyc;
  logic [15:0]      sample;
  logic [15:0]      cand;
  logic [15:0]      diff;
  logic [15:0]      nw;
  logic [2:0]       scnt;
  logic [2:0]       ncnt;
  logic [IDX_W-1:0] idx;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic [EVT_W-1:0] din;

  assign tick = enable && (timer == TW'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        timer <= '0;
    else if (tick)   timer <= '0;
    else if (enable) timer <= timer + 1'b1;
  end

  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign push      = (st == S_SCAN) && diff[idx];
  assign din       = {nw[idx], idx};
  assign drop      = push && full && !pop;

  // Count a repeated sample up to the threshold; any change restarts at 1.
  always_comb begin
    ncnt = 3'd1;
    if (sample == cand)
      ncnt = (scnt == 3'(STABLE_POLLS)) ? scnt : scnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      pad_rd      <= 1'b0;
      cyc         <= '0;
      sample      <= '0;
      cand        <= '0;
      diff        <= '0;
      nw          <= '0;
      scnt        <= '0;
      idx         <= '0;
      state       <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pad_rd <= 1'b0;
      if (ovf_clr) begin
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      unique case (st)
        S_IDLE: begin
          if (tick) begin
            st     <= S_REQ;
            pad_rd <= 1'b1;
          end
        end
        S_REQ: begin
          st  <= S_WAIT;
          cyc <= '0;
        end
        S_WAIT: begin
          if (pad_busy) begin
            st  <= S_READ;
            cyc <= '0;
          end else if (cyc == 32'(WAIT_LIMIT - 1)) begin
            timeout_err <= 1'b1;
            st          <= S_IDLE;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_READ: begin
          if (!pad_busy) begin
            sample <= ~pad_buttons;
            st     <= S_FILT;
          end else if (cyc == 32'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            st          <= S_IDLE;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_FILT: begin
          cand <= sample;
          scnt <= ncnt;
          if (ncnt == 3'(STABLE_POLLS) && sample != state) begin
            diff <= sample ^ state;
            nw   <= sample;
            idx  <= '0;
            st   <= S_SCAN;
          end else begin
            st <= S_IDLE;
          end
        end
        S_SCAN: begin
          idx <= idx + 1'b1;
          if (idx == 4'd15) begin
            state <= nw;
            st    <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  snes_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (evt_data),
    .full  (full),
    .empty (empty)
  );

endmodule
